// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel multiplexer family: mode encodings and
// a helper that extracts one channel word from a packed multi-channel bus.
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest packed bus the slice helper handles (N*WIDTH must not exceed it).
  localparam int BUS_MAX = 256;

  // Returns channel idx of a bus made of width-bit channels, right-aligned
  // and zero-filled above; callers cast the result down to their width.
  function automatic logic [BUS_MAX-1:0] chan_slice(
    input logic [BUS_MAX-1:0] bus,
    input int                 idx,
    input int                 width
  );
    logic [BUS_MAX-1:0] mask;
    mask = ~({BUS_MAX{1'b1}} << width);
    return (bus >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/chan_mux_rr_pick.sv
// Round-robin pick: the first requester after ptr, searching
// ptr+1, ptr+2, ... modulo N. Purely combinational, no state.
module rr_pick #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  int   cand;
  logic found;

  // Walk the N candidates in priority order and keep the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel multiplexer with fixed-select or round-robin arbitration and a
// single registered output stage.
//
// Handshake: every port pair is valid/ready. A word moves across a port on
// a rising edge where valid and ready are both high. Producers must hold
// data stable while valid is high and not yet accepted. in_ready is
// combinational (one-hot or zero); out_* are registered, so nothing on the
// input side reaches the output side within a cycle.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [N-1:0]     rr_gnt;
  logic [N-1:0]     fix_gnt;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  ptr;
  logic [WIDTH-1:0] word;
  logic             load;

  rr_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Fixed mode: grant the selected channel only if it exists and is valid.
  always_comb begin
    fix_gnt = '0;
    if ((int'(sel) < N) && in_valid[sel]) begin
      fix_gnt[sel] = 1'b1;
    end
  end

  // Mode mux, load enable and the input handshake. Ready is withheld during
  // reset because reset discards anything that would transfer.
  always_comb begin
    grant     = (mode == MODE_RR) ? rr_gnt : fix_gnt;
    grant_idx = (mode == MODE_RR) ? rr_idx : sel;
    load      = !out_valid || out_ready;
    in_ready  = reset ? '0 : (grant & {N{load}});
    word      = WIDTH'(chan_slice(BUS_MAX'(in_data), int'(grant_idx), WIDTH));
  end

  // Output register and round-robin pointer. The pointer follows the last
  // transfer in both modes so a switch to RR continues fairly.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(N - 1);
    end else if (load) begin
      if (|grant) begin
        out_valid <= 1'b1;
        out_data  <= word;
        out_chan  <= grant_idx;
        ptr       <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_mux_rr.sv
// Bench for chan_mux_rr: directed phases plus random traffic on an N=4,
// WIDTH=8 instance checked by a reference model and an expected-word queue,
// and a 1-bit, 2-channel instance checked against z = c ? b : a.
module tb_chan_mux_rr;
  import chan_mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  chan_mux_rr #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  logic       t_reset;
  logic [1:0] t_data;
  logic [1:0] t_valid;
  logic [1:0] t_ready;
  logic       t_mode;
  logic [0:0] t_sel;
  logic [0:0] t_odata;
  logic [0:0] t_ochan;
  logic       t_ovalid;
  logic       t_oready;

  chan_mux_rr #(.WIDTH(1), .N(2)) dut_tt (
    .clk       (clk),
    .reset     (t_reset),
    .in_data   (t_data),
    .in_valid  (t_valid),
    .in_ready  (t_ready),
    .mode      (t_mode),
    .sel       (t_sel),
    .out_data  (t_odata),
    .out_chan  (t_ochan),
    .out_valid (t_ovalid),
    .out_ready (t_oready)
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [SW+W-1:0] exp_q[$];

  // Reference model: what the output register should hold, and the last
  // channel served.
  bit m_known = 1'b0;
  bit m_valid = 1'b0;
  int m_data  = 0;
  int m_chan  = 0;
  int m_ptr   = N - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one clock cycle of stimulus, checked against the model, which
  // then advances to what the coming edge should produce.
  task automatic step(input bit rst, input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input bit md, input int s, input bit ordy);
    int           win;
    bit           load;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    mode      = md;
    sel       = SW'(s);
    out_ready = ordy;
    #1;
    if (m_known) begin
      check("out_valid", out_valid, m_valid);
      check("out_data", out_data, m_data[W-1:0]);
      check("out_chan", out_chan, m_chan[SW-1:0]);
    end
    win = -1;
    if (md) begin
      for (int k = 1; k <= N; k++)
        if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end else if (s < N && v[s]) begin
      win = s;
    end
    load    = !m_valid || ordy;
    exp_rdy = (rst || !load || win < 0) ? '0 : (N'(1) << win);
    if (rst || m_known) check("in_ready", in_ready, exp_rdy);
    if (rst) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_data  = 0;
      m_chan  = 0;
      m_ptr   = N - 1;
      exp_q.delete();
    end else if (load) begin
      if (win >= 0) begin
        m_valid = 1'b1;
        m_data  = int'(d[win*W +: W]);
        m_chan  = win;
        m_ptr   = win;
        exp_q.push_back({SW'(win), d[win*W +: W]});
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Monitor: on every accepted output word, pop and compare.
  initial begin
    logic [SW+W-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", {out_chan, out_data});
        end else begin
          e = exp_q.pop_front();
          check("out_word", {out_chan, out_data}, e);
        end
      end
    end
  end

  localparam logic [N*W-1:0] INC_DATA = 32'hA3A2A1A0;

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; mode = MODE_RR; sel = '0; out_ready = 1'b0;
    t_reset = 1'b1; t_data = '0; t_valid = '0; t_mode = MODE_FIXED; t_sel = '0; t_oready = 1'b1;

    // Reset with every channel valid; then RR fairness from channel 0.
    repeat (2) step(1, 4'hF, INC_DATA, MODE_RR, 0, 1);
    repeat (7) step(0, 4'hF, INC_DATA, MODE_RR, 0, 1);

    // RR skips idle channels, then the output drains.
    repeat (4) step(0, 4'b1010, 32'h44332211, MODE_RR, 0, 1);
    repeat (2) step(0, 4'b0000, 32'h44332211, MODE_RR, 0, 1);

    // Backpressure on a channel-2 word, then drain and fill together.
    step(0, 4'b0100, 32'h005C0000, MODE_FIXED, 2, 1);
    repeat (3) step(0, 4'hF, 32'h11223344, MODE_FIXED, 1, 0);
    step(0, 4'hF, 32'h11223344, MODE_FIXED, 1, 1);
    step(0, 4'h0, 32'h0, MODE_FIXED, 1, 1);

    // Reset during a stalled word; RR restarts at channel 0.
    step(0, 4'hF, INC_DATA, MODE_RR, 0, 0);
    step(0, 4'hF, INC_DATA, MODE_RR, 0, 0);
    step(1, 4'hF, INC_DATA, MODE_RR, 0, 0);
    repeat (3) step(0, 4'hF, INC_DATA, MODE_RR, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, N'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, N - 1), $urandom_range(0, 3) != 0);
    end
    repeat (4) step(0, 4'h0, 32'h0, MODE_RR, 0, 1);
    check("queue_empty", exp_q.size(), 0);

    // Two-channel 1-bit instance: z = c ? b : a for all a, b, c.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      @(negedge clk);
      t_reset = 1'b0; t_data = {abc[1], abc[0]}; t_valid = 2'b11;
      t_sel = abc[2]; t_mode = MODE_FIXED; t_oready = 1'b1;
      @(posedge clk);
      #1;
      check("tt_valid", t_ovalid, 1'b1);
      check("tt_data", t_odata, (abc[2] & abc[1]) | (abc[0] & ~abc[2]));
      check("tt_chan", t_ochan, abc[2]);
    end
    @(negedge clk);
    t_sel = 1'b1; t_valid = 2'b01;
    #1;
    check("tt_ready_none", t_ready, 2'b00);
    @(posedge clk);
    #1;
    check("tt_no_xfer", t_ovalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
